// File: rtl/counter_op_pkg.sv
// ---------------------------------------------------------------------------
// counter_op_pkg
// Shared types and constants for the counter op scheduler.
//   cnt_op_t  : two-bit op code carried on each requester's req_op slice
//   CNT_WIDTH : default width of the count registers and data words
// ---------------------------------------------------------------------------
package counter_op_pkg;

    typedef enum logic [1:0] {
        OP_INC  = 2'b00,
        OP_ROL  = 2'b01,
        OP_LOAD = 2'b10,
        OP_READ = 2'b11
    } cnt_op_t;

    localparam int CNT_WIDTH = 8;

endpackage : counter_op_pkg

// File: rtl/counter_op_alu.sv
// ---------------------------------------------------------------------------
// counter_op_alu
// Combinational next-value unit shared by all channels.
//   op       in  : operation to apply
//   cur      in  : current value of the granted channel's count register
//   load_val in  : value used by OP_LOAD
//   nxt      out : value written back to the channel register
// ---------------------------------------------------------------------------
module counter_op_alu
    import counter_op_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH
) (
    input  cnt_op_t            op,
    input  logic [WIDTH-1:0]   cur,
    input  logic [WIDTH-1:0]   load_val,
    output logic [WIDTH-1:0]   nxt
);

    // Select the result of the requested operation.
    always_comb begin
        nxt = cur;
        case (op)
            OP_INC:  nxt = cur + WIDTH'(1);
            OP_ROL:  nxt = {cur[WIDTH-2:0], cur[WIDTH-1]};
            OP_LOAD: nxt = load_val;
            OP_READ: nxt = cur;
            default: nxt = cur;
        endcase
    end

endmodule : counter_op_alu

// File: rtl/counter_op_scheduler.sv
// ---------------------------------------------------------------------------
// counter_op_scheduler
// Round-robin scheduler sharing one counter ALU among NREQ channels, each
// with a private count register, and returning the updated value through a
// single registered valid/ready response port.
//   clk        in  : clock
//   rst        in  : synchronous active-low reset
//   req_valid  in  : per-requester request valid
//   req_op     in  : per-requester op code (2 bits each)
//   req_data   in  : per-requester LOAD value (WIDTH bits each)
//   req_ready  out : one-hot grant (combinational)
//   resp_valid out : response register holds a result
//   resp_ready in  : consumer accepts the response
//   resp_id    out : requester the response belongs to
//   resp_data  out : channel register value after the op
// ---------------------------------------------------------------------------
module counter_op_scheduler
    import counter_op_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = CNT_WIDTH,
    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*2-1:0]       req_op,
    input  logic [NREQ*WIDTH-1:0]   req_data,
    output logic [NREQ-1:0]         req_ready,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [IDW-1:0]          resp_id,
    output logic [WIDTH-1:0]        resp_data
);

    logic [WIDTH-1:0] cnt_q [NREQ];
    logic [WIDTH-1:0] cnt_d [NREQ];
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic             resp_valid_q, resp_valid_d;
    logic [IDW-1:0]   resp_id_q, resp_id_d;
    logic [WIDTH-1:0] resp_data_q, resp_data_d;

    logic [1:0]       op_arr_s   [NREQ];
    logic [WIDTH-1:0] data_arr_s [NREQ];
    logic             can_issue_s;
    logic             found_s;
    logic [IDW-1:0]   gnt_id_s;
    logic [NREQ-1:0]  grant_s;
    logic             accept_s;
    logic [WIDTH-1:0] alu_nxt_s;

    // Split the flat request buses into per-channel fields.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            op_arr_s[i]   = req_op[i*2 +: 2];
            data_arr_s[i] = req_data[i*WIDTH +: WIDTH];
        end
    end

    // Round-robin search: first valid requester at or after the pointer.
    always_comb begin
        logic [IDW:0] k_w;
        logic [IDW-1:0] k_s;
        found_s  = 1'b0;
        gnt_id_s = '0;
        k_w      = '0;
        k_s      = '0;
        for (int i = 0; i < NREQ; i++) begin
            k_w = {1'b0, ptr_q} + (IDW+1)'(i);
            if (k_w >= (IDW+1)'(NREQ)) begin
                k_w = k_w - (IDW+1)'(NREQ);
            end else begin
                k_w = k_w;
            end
            k_s = k_w[IDW-1:0];
            if (!found_s && req_valid[k_s]) begin
                found_s  = 1'b1;
                gnt_id_s = k_s;
            end else begin
                found_s  = found_s;
            end
        end
    end

    // Grant only when the response slot is free or draining this cycle.
    always_comb begin
        can_issue_s = !resp_valid_q || resp_ready;
        grant_s     = '0;
        if (rst && can_issue_s && found_s) begin
            grant_s[gnt_id_s] = 1'b1;
        end else begin
            grant_s = '0;
        end
        accept_s  = |grant_s;
        req_ready = grant_s;
    end

    counter_op_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .op       (cnt_op_t'(op_arr_s[gnt_id_s])),
        .cur      (cnt_q[gnt_id_s]),
        .load_val (data_arr_s[gnt_id_s]),
        .nxt      (alu_nxt_s)
    );

    // Next state of count registers, pointer and response register.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            cnt_d[i] = cnt_q[i];
        end
        ptr_d        = ptr_q;
        resp_valid_d = resp_valid_q;
        resp_id_d    = resp_id_q;
        resp_data_d  = resp_data_q;
        if (accept_s) begin
            cnt_d[gnt_id_s] = alu_nxt_s;
            resp_valid_d    = 1'b1;
            resp_id_d       = gnt_id_s;
            resp_data_d     = alu_nxt_s;
            if (gnt_id_s == IDW'(NREQ - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = gnt_id_s + IDW'(1);
            end
        end else if (resp_valid_q && resp_ready) begin
            resp_valid_d = 1'b0;
        end else begin
            resp_valid_d = resp_valid_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREQ; i++) begin
                cnt_q[i] <= '0;
            end
            ptr_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_data_q  <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            ptr_q        <= ptr_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_data_q  <= resp_data_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_id    = resp_id_q;
    assign resp_data  = resp_data_q;

endmodule : counter_op_scheduler

// File: tb/tb_counter_op_scheduler.sv
// ---------------------------------------------------------------------------
// tb_counter_op_scheduler
// Directed vector table for the documented scenarios, then randomized
// traffic compared against a behavioural model of the scheduler.
// ---------------------------------------------------------------------------
module tb_counter_op_scheduler;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [7:0]  req_op;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        resp_valid;
    logic        resp_ready;
    logic [1:0]  resp_id;
    logic [7:0]  resp_data;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    counter_op_scheduler #(
        .NREQ  (NREQ),
        .WIDTH (WIDTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_op     (req_op),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_data  (resp_data)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) begin
            passes++;
        end else begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    int m_cnt [NREQ];
    int m_ptr;
    bit m_rv;
    int m_id;
    int m_data;

    function automatic int m_grant(input bit [3:0] v, input bit rr);
        if (m_rv && !rr) return -1;
        for (int i = 0; i < NREQ; i++) begin
            if (v[(m_ptr + i) % NREQ]) return (m_ptr + i) % NREQ;
        end
        return -1;
    endfunction

    function automatic int m_apply(input int op, input int cur, input int ld);
        case (op)
            0: return (cur + 1) % 256;
            1: return ((cur * 2) % 256) + (cur / 128);
            2: return ld;
            default: return cur;
        endcase
    endfunction

    task automatic m_reset();
        for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
        m_ptr = 0; m_rv = 0; m_id = 0; m_data = 0;
    endtask

    task automatic m_clock(input bit rs, input bit [3:0] v, input bit [7:0] op,
                           input bit [31:0] d, input bit rr);
        int g;
        if (!rs) begin
            m_reset();
        end else begin
            g = m_grant(v, rr);
            if (g >= 0) begin
                m_cnt[g] = m_apply(int'(op[g*2 +: 2]), m_cnt[g], int'(d[g*8 +: 8]));
                m_rv = 1; m_id = g; m_data = m_cnt[g];
                m_ptr = (g + 1) % NREQ;
            end else if (m_rv && rr) begin
                m_rv = 0;
            end
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        rs;
        logic [3:0]  v;
        logic [7:0]  op;
        logic [31:0] d;
        logic        rr;
        logic [3:0]  e_rdy;
        logic        e_rv;
        logic [1:0]  e_id;
        logic [7:0]  e_data;
    } vec_t;

    vec_t vecs [$];

    bit        pv  [NREQ];
    bit [1:0]  pop [NREQ];
    bit [7:0]  pd  [NREQ];

    function automatic bit [7:0] rand_data();
        case ($urandom_range(0, 3))
            0: return 8'hFF;
            1: return 8'h80;
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    initial begin
        int g;
        bit [3:0] exp_rdy;

        rst = 1'b0; req_valid = 4'b0000; req_op = 8'h00; req_data = 32'h0; resp_ready = 1'b1;

        // reset, then scenarios 1-6
        vecs.push_back('{1'b0, 4'b0001, 8'h00, 32'h0, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00});
        vecs.push_back('{1'b0, 4'b0001, 8'h00, 32'h0, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00});
        vecs.push_back('{1'b1, 4'b0001, 8'h00, 32'h0, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h01});
        vecs.push_back('{1'b1, 4'b0001, 8'h00, 32'h0, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h02});
        vecs.push_back('{1'b1, 4'b0001, 8'h00, 32'h0, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h03});
        vecs.push_back('{1'b1, 4'b0010, 8'h08, 32'h0000FF00, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hFF});
        vecs.push_back('{1'b1, 4'b0010, 8'h00, 32'h0, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h00});
        vecs.push_back('{1'b1, 4'b0100, 8'h20, 32'h00810000, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h81});
        vecs.push_back('{1'b1, 4'b0100, 8'h10, 32'h0, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h03});
        vecs.push_back('{1'b1, 4'b0100, 8'h10, 32'h0, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h06});
        vecs.push_back('{1'b1, 4'b0000, 8'h00, 32'h0, 1'b1, 4'b0000, 1'b0, 2'd2, 8'h06});
        vecs.push_back('{1'b1, 4'b1000, 8'hC0, 32'h0, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h00});
        vecs.push_back('{1'b1, 4'b1111, 8'hFF, 32'h0, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h03});
        vecs.push_back('{1'b1, 4'b1111, 8'hFF, 32'h0, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h00});
        vecs.push_back('{1'b1, 4'b1111, 8'hFF, 32'h0, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h06});
        vecs.push_back('{1'b1, 4'b1111, 8'hFF, 32'h0, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h00});
        vecs.push_back('{1'b1, 4'b1111, 8'hFF, 32'h0, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h03});
        vecs.push_back('{1'b1, 4'b0011, 8'h0F, 32'h0, 1'b0, 4'b0000, 1'b1, 2'd0, 8'h03});
        vecs.push_back('{1'b1, 4'b0011, 8'h0F, 32'h0, 1'b0, 4'b0000, 1'b1, 2'd0, 8'h03});
        vecs.push_back('{1'b1, 4'b0011, 8'h0F, 32'h0, 1'b0, 4'b0000, 1'b1, 2'd0, 8'h03});
        vecs.push_back('{1'b1, 4'b0011, 8'h0F, 32'h0, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h00});
        vecs.push_back('{1'b0, 4'b0011, 8'h0F, 32'h0, 1'b0, 4'b0000, 1'b0, 2'd0, 8'h00});
        vecs.push_back('{1'b1, 4'b0001, 8'h03, 32'h0, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h00});
        vecs.push_back('{1'b1, 4'b0100, 8'h30, 32'h0, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h00});

        foreach (vecs[i]) begin
            @(negedge clk);
            rst = vecs[i].rs; req_valid = vecs[i].v; req_op = vecs[i].op;
            req_data = vecs[i].d; resp_ready = vecs[i].rr;
            #1;
            chk($sformatf("vec%0d_req_ready", i), int'(req_ready), int'(vecs[i].e_rdy));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_resp_valid", i), int'(resp_valid), int'(vecs[i].e_rv));
            chk($sformatf("vec%0d_resp_id", i), int'(resp_id), int'(vecs[i].e_id));
            chk($sformatf("vec%0d_resp_data", i), int'(resp_data), int'(vecs[i].e_data));
        end

        // randomized traffic against the model, starting from reset
        @(negedge clk);
        rst = 1'b0; req_valid = 4'b0000; resp_ready = 1'b1;
        @(posedge clk);
        m_reset();
        for (int i = 0; i < NREQ; i++) begin
            pv[i] = 0; pop[i] = 2'b00; pd[i] = 8'h00;
        end

        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 99) != 0);
            resp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NREQ; i++) begin
                req_valid[i]          = pv[i];
                req_op[i*2 +: 2]      = pop[i];
                req_data[i*8 +: 8]    = pd[i];
            end
            #1;
            g = rst ? m_grant(req_valid, resp_ready) : -1;
            exp_rdy = (g >= 0) ? 4'(1 << g) : 4'b0000;
            chk("rand_req_ready", int'(req_ready), int'(exp_rdy));
            chk("rand_resp_valid", int'(resp_valid), int'(m_rv));
            chk("rand_resp_id", int'(resp_id), m_id);
            chk("rand_resp_data", int'(resp_data), m_data);
            @(posedge clk);
            m_clock(rst, req_valid, req_op, req_data, resp_ready);
            if (g >= 0) pv[g] = 0;
            for (int i = 0; i < NREQ; i++) begin
                if (!pv[i] && $urandom_range(0, 1) == 1) begin
                    pv[i]  = 1;
                    pop[i] = 2'($urandom_range(0, 3));
                    pd[i]  = rand_data();
                end
            end
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule : tb_counter_op_scheduler
